// File: rtl/idli_sqi_ctl_m.sv
// rtl/idli_sqi_ctl_m.sv - SQI SRAM port arbiter and nibble-serial transaction sequencer
module idli_sqi_ctl_m #(
  parameter int BURST_NIBBLES = 4
) (
  input  logic        i_sqi_gck,
  input  logic        i_sqi_rst_n,
  input  logic        i_sqi_req0,
  input  logic [15:0] i_sqi_addr0,
  output logic        o_sqi_gnt0,
  input  logic        i_sqi_req1,
  input  logic [15:0] i_sqi_addr1,
  input  logic        i_sqi_wr1,
  output logic        o_sqi_gnt1,
  input  logic [3:0]  i_sqi_wdata,
  output logic        o_sqi_wr_rdy,
  output logic [3:0]  o_sqi_rdata,
  output logic        o_sqi_rvld,
  output logic        o_sqi_rid,
  output logic        o_sqi_cs_n,
  output logic [3:0]  o_sqi_sio_out,
  output logic        o_sqi_sio_oe,
  input  logic [3:0]  i_sqi_sio_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL
  } state_t;

  localparam logic [2:0] LP_BURST_M1 = 3'(BURST_NIBBLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_cnt;
  logic        r_last;
  logic        r_rid;
  logic        r_wr;
  logic [15:0] r_addr;
  logic        w_gnt0;
  logic        w_gnt1;
  logic [23:0] w_baddr;

  assign w_baddr = {7'b0, r_addr, 1'b0};

  // Grants are gated by reset so nothing is offered while the port is held in reset.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_sqi_rst_n) begin
          if (i_sqi_req0 && (!i_sqi_req1 || r_last)) w_gnt0 = 1'b1;
          else if (i_sqi_req1)                       w_gnt1 = 1'b1;
        end
        if (w_gnt0 || w_gnt1) w_next = S_CMD;
      end
      S_CMD:   if (r_cnt == 3'd1) w_next = S_ADDR;
      S_ADDR:  if (r_cnt == 3'd5) w_next = r_wr ? S_DATA : S_DUMMY;
      S_DUMMY: if (r_cnt == 3'd1) w_next = S_DATA;
      S_DATA:  if (r_cnt == LP_BURST_M1) w_next = S_DESEL;
      S_DESEL: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
    if (!i_sqi_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_last  <= 1'b1;
      r_rid   <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 16'h0000;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 3'd0 : r_cnt + 3'd1;
      if (w_gnt0) begin
        r_last <= 1'b0;
        r_rid  <= 1'b0;
        r_wr   <= 1'b0;
        r_addr <= i_sqi_addr0;
      end else if (w_gnt1) begin
        r_last <= 1'b1;
        r_rid  <= 1'b1;
        r_wr   <= i_sqi_wr1;
        r_addr <= i_sqi_addr1;
      end
    end
  end

  always_comb begin
    o_sqi_cs_n    = 1'b1;
    o_sqi_sio_oe  = 1'b0;
    o_sqi_sio_out = 4'h0;
    o_sqi_rvld    = 1'b0;
    o_sqi_rdata   = 4'h0;
    o_sqi_wr_rdy  = 1'b0;
    case (r_state)
      S_CMD: begin
        o_sqi_cs_n    = 1'b0;
        o_sqi_sio_oe  = 1'b1;
        o_sqi_sio_out = r_cnt[0] ? {3'b001, ~r_wr} : 4'h0;
      end
      S_ADDR: begin
        o_sqi_cs_n    = 1'b0;
        o_sqi_sio_oe  = 1'b1;
        o_sqi_sio_out = w_baddr[5'd20 - {r_cnt, 2'b00} +: 4];
      end
      S_DUMMY: o_sqi_cs_n = 1'b0;
      S_DATA: begin
        o_sqi_cs_n = 1'b0;
        if (r_wr) begin
          o_sqi_wr_rdy  = 1'b1;
          o_sqi_sio_oe  = 1'b1;
          o_sqi_sio_out = i_sqi_wdata;
        end else begin
          o_sqi_rvld  = 1'b1;
          o_sqi_rdata = i_sqi_sio_in;
        end
      end
      default: ;
    endcase
  end

  assign o_sqi_gnt0 = w_gnt0;
  assign o_sqi_gnt1 = w_gnt1;
  assign o_sqi_rid  = r_rid;

endmodule

// File: tb/tb_idli_sqi_ctl_m.sv
// tb/tb_idli_sqi_ctl_m.sv - directed table and sequence bench for idli_sqi_ctl_m
module tb_idli_sqi_ctl_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr0 = 16'h1234, addr1 = 16'h0001;
  logic [3:0]  wdata = 4'h0, sio_in = 4'h0;
  logic        gnt0, gnt1, wr_rdy, rvld, rid, cs_n, oe;
  logic [3:0]  rdata, sio_out;
  logic        req0_b = 1'b0;
  logic        gnt0_b, gnt1_b, wr_rdy_b, rvld_b, rid_b, cs_n_b, oe_b;
  logic [3:0]  rdata_b, sio_out_b;

  always #5 clk = ~clk;

  idli_sqi_ctl_m #(.BURST_NIBBLES(4)) u_dut (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n),
    .i_sqi_req0(req0), .i_sqi_addr0(addr0), .o_sqi_gnt0(gnt0),
    .i_sqi_req1(req1), .i_sqi_addr1(addr1), .i_sqi_wr1(wr1), .o_sqi_gnt1(gnt1),
    .i_sqi_wdata(wdata), .o_sqi_wr_rdy(wr_rdy), .o_sqi_rdata(rdata), .o_sqi_rvld(rvld),
    .o_sqi_rid(rid), .o_sqi_cs_n(cs_n), .o_sqi_sio_out(sio_out), .o_sqi_sio_oe(oe),
    .i_sqi_sio_in(sio_in)
  );

  idli_sqi_ctl_m #(.BURST_NIBBLES(1)) u_dut1 (
    .i_sqi_gck(clk), .i_sqi_rst_n(rst_n),
    .i_sqi_req0(req0_b), .i_sqi_addr0(16'h0040), .o_sqi_gnt0(gnt0_b),
    .i_sqi_req1(1'b0), .i_sqi_addr1(16'h0000), .i_sqi_wr1(1'b0), .o_sqi_gnt1(gnt1_b),
    .i_sqi_wdata(4'h0), .o_sqi_wr_rdy(wr_rdy_b), .o_sqi_rdata(rdata_b), .o_sqi_rvld(rvld_b),
    .o_sqi_rid(rid_b), .o_sqi_cs_n(cs_n_b), .o_sqi_sio_out(sio_out_b), .o_sqi_sio_oe(oe_b),
    .i_sqi_sio_in(4'h7)
  );

  typedef struct {
    logic        req0, req1, wr1;
    logic [3:0]  sio_in, wdata;
    logic [14:0] exp;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [14:0] outs();
    return {gnt0, gnt1, cs_n, oe, sio_out, rvld, rdata, wr_rdy, rid};
  endfunction

  function automatic vec_t mk(input logic r0, input logic r1, input logic w,
                              input logic [3:0] si, input logic [3:0] wd,
                              input logic g0, input logic g1, input logic cs, input logic e,
                              input logic [3:0] so, input logic rv, input logic [3:0] rd,
                              input logic wrr, input logic id);
    vec_t v;
    v.req0 = r0; v.req1 = r1; v.wr1 = w; v.sio_in = si; v.wdata = wd;
    v.exp = {g0, g1, cs, e, so, rv, rd, wrr, id};
    return v;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] rd_nib [4];
    logic [3:0] ad_rd  [6];
    logic [3:0] ad_wr  [6];
    int         g_cyc [4];
    logic [3:0] g_ids;
    int         n_g, both, n_rv, bad_rid, n_cs;

    rd_nib = '{4'hA, 4'hB, 4'hC, 4'hD};
    ad_rd  = '{4'h0, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8};
    ad_wr  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};

    // read by fetch right after reset, then write by execute
    vecs.push_back(mk(1,0,0,0,0, 1,0,1,0,4'h0,0,4'h0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,4'h0,0,4'h0,0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,4'h3,0,4'h0,0,0));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0,0,0,0,0, 0,0,0,1,ad_rd[i],0,4'h0,0,0));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,4'h0,0,4'h0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,rd_nib[i],0, 0,0,0,0,4'h0,1,rd_nib[i],0,0));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,4'h0,0,4'h0,0,0));
    vecs.push_back(mk(0,1,1,0,0, 0,1,1,0,4'h0,0,4'h0,0,0));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1,4'h0,0,4'h0,0,1));
    vecs.push_back(mk(0,0,1,0,0, 0,0,0,1,4'h2,0,4'h0,0,1));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(0,0,1,0,0, 0,0,0,1,ad_wr[i],0,4'h0,0,1));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,0,1,0,4'(i+1), 0,0,0,1,4'(i+1),0,4'h0,1,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,4'h0,0,4'h0,0,1));
    vecs.push_back(mk(0,0,0,0,0, 0,0,1,0,4'h0,0,4'h0,0,1));

    req0 = 1'b1;
    @(negedge clk);
    #1 chk("reset_outputs", {17'h0, outs()}, {17'h0, 15'b001_0_0000_0_0000_0_0});
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      req0 = vecs[i].req0; req1 = vecs[i].req1; wr1 = vecs[i].wr1;
      sio_in = vecs[i].sio_in; wdata = vecs[i].wdata;
      #1 chk($sformatf("vec%0d", i), {17'h0, outs()}, {17'h0, vecs[i].exp});
      @(negedge clk);
    end

    // round robin with both requesters held high
    req0 = 1'b0; req1 = 1'b0; wr1 = 1'b0; sio_in = 4'h0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    n_g = 0; both = 0; g_ids = 4'h0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (gnt0 && gnt1) both++;
      if ((gnt0 || gnt1) && n_g < 4) begin
        g_ids[n_g] = gnt1;
        g_cyc[n_g] = c;
        n_g++;
      end
      @(negedge clk);
    end
    chk("rr_count", n_g, 4);
    chk("rr_order", {28'h0, g_ids}, 32'b1010);
    chk("rr_first_cycle", g_cyc[0], 0);
    for (int k = 1; k < 4; k++) chk($sformatf("rr_gap%0d", k), g_cyc[k] - g_cyc[k-1], 16);
    chk("rr_both", both, 0);

    // reset at the second data cycle of a fetch read, execute pending
    req0 = 1'b0; req1 = 1'b0;
    do_reset();
    req0 = 1'b1; req1 = 1'b1; wr1 = 1'b0;
    #1 chk("mid_gnt0", {30'h0, gnt0, gnt1}, 32'b10);
    @(negedge clk);
    req0 = 1'b0;
    repeat (11) @(negedge clk);
    sio_in = 4'h5;
    #1 chk("mid_in_data", {29'h0, rvld, rid, cs_n}, 32'b100);
    rst_n = 1'b0;
    #1 chk("mid_reset_outs", {27'h0, cs_n, oe, rvld, gnt0, gnt1}, 32'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_reset_gnt1", {30'h0, gnt0, gnt1}, 32'b01);
    @(negedge clk);
    req1 = 1'b0;
    n_rv = 0; bad_rid = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (rvld) begin
        n_rv++;
        if (rid !== 1'b1) bad_rid++;
        if (rdata !== sio_in) bad_rid++;
      end
      @(negedge clk);
    end
    chk("pulse_rvld_count", n_rv, 4);
    chk("pulse_rid_data", bad_rid, 0);

    // single-nibble build
    req0_b = 1'b1;
    n_rv = 0; n_cs = 0;
    #1 chk("b1_gnt", {31'h0, gnt0_b}, 32'h1);
    @(negedge clk);
    req0_b = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!cs_n_b) n_cs++;
      if (rvld_b) n_rv++;
      @(negedge clk);
    end
    chk("b1_rvld_count", n_rv, 1);
    chk("b1_cs_low", n_cs, 11);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
